// File: rtl/uart_rx_pkg.sv
// ============================================================================
// uart_rx_pkg : shared receiver FSM encoding and STATUS register bit positions
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   // STATUS bit positions, also used by the transmitter's status register
   localparam int unsigned STAT_NE   = 0;
   localparam int unsigned STAT_FERR = 1;
   localparam int unsigned STAT_OVR  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// sync_fifo : single-clock circular FIFO, pointers one bit wider than address
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty   = (wptr_q == rptr_q);
      full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_pop  = pop && !empty;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      do_push = push && (!full || do_pop);
      wptr_d  = do_push ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d  = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;
      head    = mem_q[rptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : memory-mapped 8N1 receiver, 16x oversampling, byte FIFO, sticky errors
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKDIV     = 27,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx,
   input  logic        re,
   input  logic        addr,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [15:0] TICK_MAX = 16'(CLKDIV - 1);

   logic        rx_meta_q, rx_meta_d;
   logic        rx_s_q, rx_s_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic        tick;
   rx_state_e   state_q, state_d;
   logic [3:0]  sc_q, sc_d;
   logic [2:0]  bc_q, bc_d;
   logic [7:0]  shift_q, shift_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;

   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_head;
   logic        ferr_set;
   logic        ovr_set;
   logic        stat_clr;

   always_comb begin
      rx_meta_d  = rx;
      rx_s_d     = rx_meta_q;
      tick       = (tick_cnt_q == TICK_MAX);
      tick_cnt_d = tick ? 16'd0 : (tick_cnt_q + 16'd1);
   end

   always_comb begin
      state_d   = state_q;
      sc_d      = sc_q;
      bc_d      = bc_q;
      shift_d   = shift_q;
      fifo_push = 1'b0;
      ferr_set  = 1'b0;
      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  sc_d    = 4'd0;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (sc_q == 4'd7) begin
                  if (!rx_s_q) begin
                     sc_d    = 4'd0;
                     bc_d    = 3'd0;
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  sc_d = sc_q + 4'd1;
               end
            end
            ST_DATA: begin
               // sc wraps 15 -> 0, so each bit is sampled one bit time later
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd15) begin
                  shift_d = {rx_s_q, shift_q[7:1]};
                  bc_d    = bc_q + 3'd1;
                  if (bc_q == 3'd7) begin
                     state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd15) begin
                  if (rx_s_q) begin
                     fifo_push = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_d  = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s_q) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      fifo_pop = re && !addr && !fifo_empty;
      stat_clr = re && addr;
      ovr_set  = fifo_push && fifo_full && !fifo_pop;
      // a new error in the clearing cycle survives the clear
      ferr_d   = (ferr_q && !stat_clr) || ferr_set;
      ovr_d    = (ovr_q  && !stat_clr) || ovr_set;
      irq      = !fifo_empty;
      rdata    = 32'd0;
      if (addr) begin
         rdata[STAT_NE]   = !fifo_empty;
         rdata[STAT_FERR] = ferr_q;
         rdata[STAT_OVR]  = ovr_q;
      end else if (!fifo_empty) begin
         rdata[7:0] = fifo_head;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         tick_cnt_q <= 16'd0;
         state_q    <= ST_IDLE;
         sc_q       <= 4'd0;
         bc_q       <= 3'd0;
         shift_q    <= 8'd0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_meta_q  <= rx_meta_d;
         rx_s_q     <= rx_s_d;
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         sc_q       <= sc_d;
         bc_q       <= bc_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wdata   (shift_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx with a queue-based reference model
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

   localparam int unsigned CLKDIV  = 4;
   localparam int          BIT_CYC = 64;
   localparam int          DEPTH   = 4;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx      = 1'b1;
   logic        re      = 1'b0;
   logic        addr    = 1'b0;
   logic [31:0] rdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   // reference model: received bytes in arrival order plus sticky flags
   logic [7:0] exp_q[$];
   logic       exp_ovr  = 1'b0;
   logic       exp_ferr = 1'b0;
   logic [7:0] mon_b;

   uart_rx #(
      .CLKDIV     (CLKDIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .re      (re),
      .addr    (addr),
      .rdata   (rdata),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   // monitor: every bus read is compared against the model when it happens
   always @(negedge clk) begin
      if (re && reset_n) begin
         if (!addr) begin
            if (exp_q.size() > 0) begin
               mon_b = exp_q.pop_front();
               check("data_read", rdata, {24'h0, mon_b});
            end else begin
               check("data_read_empty", rdata, 32'h0);
            end
         end else begin
            check("status_read", rdata, {29'h0, exp_ovr, exp_ferr, exp_q.size() != 0});
            exp_ovr  = 1'b0;
            exp_ferr = 1'b0;
         end
      end
   end

   task automatic rd(input logic a);
      @(posedge clk); #1;
      re   = 1'b1;
      addr = a;
      @(posedge clk); #1;
      re   = 1'b0;
      addr = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bitc, input bit bad_stop);
      rx = 1'b0;
      repeat (bitc) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bitc) @(posedge clk);
      end
      if (bad_stop) begin
         rx = 1'b0;
         repeat (2 * bitc) @(posedge clk);
      end
      rx = 1'b1;
      repeat (bitc) @(posedge clk);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, BIT_CYC, 1'b0);
      model_push(b);
   endtask

   task automatic check_irq(input string name);
      @(posedge clk); #1;
      check(name, irq, exp_q.size() != 0);
   endtask

   task automatic drain();
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) rd(1'b0);
   endtask

   initial begin
      #4ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      int burst;
      logic [7:0] b;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_irq", irq, 1'b0);
      check("rst_rdata_data", rdata, 32'h0);
      addr = 1'b1; #1;
      check("rst_rdata_status", rdata, 32'h0);
      addr = 1'b0;
      reset_n = 1'b1;
      repeat (10) @(posedge clk);

      // single byte
      send_good(8'h55);
      check_irq("single_irq_set");
      rd(1'b1);
      rd(1'b0);
      rd(1'b1);
      check_irq("single_irq_clear");

      // start-bit glitch
      rx = 1'b0;
      repeat (20) @(posedge clk);
      rx = 1'b1;
      repeat (200) @(posedge clk);
      rd(1'b1);
      check_irq("glitch_no_push");
      send_good(8'h3C);
      rd(1'b0);

      // framing error
      send_frame(8'hA5, BIT_CYC, 1'b1);
      exp_ferr = 1'b1;
      repeat (20) @(posedge clk);
      check_irq("ferr_no_push");
      rd(1'b1);
      rd(1'b1);
      send_good(8'h81);
      rd(1'b0);

      // overrun: five bytes into a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_good(8'(i));
      rd(1'b1);
      drain();
      rd(1'b0);
      rd(1'b1);
      check_irq("ovr_drained");

      // same-cycle pop and push while full
      for (int i = 0; i < 4; i++) send_good(8'h21 + 8'(i));
      seen = 1'b0;
      fork
         send_frame(8'h25, BIT_CYC, 1'b0);
         begin
            for (int n = 0; n < 800 && !seen; n++) begin
               @(posedge clk); #1;
               if (dut.fifo_push) begin
                  re   = 1'b1;
                  addr = 1'b0;
                  seen = 1'b1;
                  @(posedge clk); #1;
                  re = 1'b0;
                  // the concurrent pop made room, so the byte is kept
                  exp_q.push_back(8'h25);
               end
            end
         end
      join
      check("popush_seen", seen, 1'b1);
      rd(1'b1);
      drain();
      check_irq("popush_drained");

      // reset mid-frame with a byte already queued
      send_good(8'h5A);
      rx = 1'b0;
      repeat (BIT_CYC) @(posedge clk);
      rx = 1'b0;
      repeat (3 * BIT_CYC) @(posedge clk);
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
      repeat (3) @(posedge clk);
      rx = 1'b1;
      #1;
      check("midrst_irq", irq, 1'b0);
      check("midrst_data", rdata, 32'h0);
      addr = 1'b1; #1;
      check("midrst_status", rdata, 32'h0);
      addr = 1'b0;
      reset_n = 1'b1;
      repeat (200) @(posedge clk);
      check_irq("midrst_empty");
      send_good(8'h7E);
      rd(1'b0);

      // random back-to-back bursts with +/-1.5% baud mismatch
      for (int k = 0; k < 8; k++) begin
         burst = $urandom_range(1, 3);
         for (int j = 0; j < burst; j++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(BIT_CYC - 1, BIT_CYC + 1), 1'b0);
            model_push(b);
         end
         repeat (8) @(posedge clk);
         check_irq("rand_irq");
         drain();
         rd(1'b1);
         repeat ($urandom_range(0, 100)) @(posedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
